// File: rtl/biu_constants_pkg.sv
// Shared BIU encodings and the burst-length helper used by the write buffer and the port mux.
package biu_constants_pkg;

    typedef enum logic [2:0] {BYTE, HWORD, WORD, DWORD, QWORD, OWORD} biu_size_t;

    typedef enum logic [2:0] {
        SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t PROT_DATA       = 3'b001;
    localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
    localparam biu_prot_t PROT_NONSECURE  = 3'b100;

    typedef enum logic [1:0] {WB_IDLE, WB_WDATA, WB_PASS} wbuf_state_t;

    // Number of beats remaining after the first one; undefined-length INCR is one beat.
    function automatic logic [3:0] biu_type2cnt(input biu_type_t t);
        case (t)
            WRAP4,  INCR4:  return 4'd3;
            WRAP8,  INCR8:  return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/biu_wbuf_fifo.sv
// Synchronous FIFO with a combinational head; pointers carry one extra bit to tell full from empty.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr - rd_ptr) == FULLC);

endmodule

// File: rtl/biu_wbuf.sv
// Posted-write buffer in front of a BIU mux port: single writes are queued and acked at once,
// everything else waits for the queue to drain and is then passed straight through.
module biu_wbuf
    import biu_constants_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 up_req_i,
    output logic                 up_req_ack_o,
    input  logic [ADDR_SIZE-1:0] up_adri_i,
    input  biu_size_t            up_size_i,
    input  biu_type_t            up_type_i,
    input  logic                 up_lock_i,
    input  biu_prot_t            up_prot_i,
    input  logic                 up_we_i,
    input  logic [DATA_SIZE-1:0] up_d_i,
    output logic [DATA_SIZE-1:0] up_q_o,
    output logic                 up_ack_o,
    output logic                 up_err_o,
    output logic                 wbuf_err_o,
    input  logic                 wbuf_err_clr_i,
    output logic                 wbuf_empty_o,
    output logic                 biu_req_o,
    input  logic                 biu_req_ack_i,
    input  logic                 biu_d_ack_i,
    output logic [ADDR_SIZE-1:0] biu_adri_o,
    input  logic [ADDR_SIZE-1:0] biu_adro_i,
    output biu_size_t            biu_size_o,
    output biu_type_t            biu_type_o,
    output logic                 biu_lock_o,
    output biu_prot_t            biu_prot_o,
    output logic                 biu_we_o,
    output logic [DATA_SIZE-1:0] biu_d_o,
    input  logic [DATA_SIZE-1:0] biu_q_i,
    input  logic                 biu_ack_i,
    input  logic                 biu_err_i
);
    typedef struct packed {
        logic [ADDR_SIZE-1:0] adr;
        biu_size_t            size;
        biu_prot_t            prot;
        logic [DATA_SIZE-1:0] d;
    } wbuf_entry_t;

    localparam int EW = $bits(wbuf_entry_t);

    wbuf_state_t  state;
    logic [3:0]   burst_cnt;
    wbuf_entry_t  wr_entry, head;
    logic [EW-1:0] head_bits;
    logic         fifo_full, fifo_empty, postable, push, pop;
    logic         unused_ok;

    assign unused_ok = ^{biu_d_ack_i, biu_adro_i};

    assign postable = up_we_i & (up_type_i == SINGLE) & ~up_lock_i;
    assign pop      = ~rst_i & (state == WB_WDATA) & (biu_ack_i | biu_err_i);
    // A full queue still takes a write in the cycle its head retires.
    assign push     = ~rst_i & up_req_i & postable & (~fifo_full | pop);
    assign wr_entry = '{adr: up_adri_i, size: up_size_i, prot: up_prot_i, d: up_d_i};
    assign head     = wbuf_entry_t'(head_bits);

    wbuf_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_bits)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= WB_IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                WB_IDLE:
                    if (!fifo_empty) begin
                        if (biu_req_ack_i) state <= WB_WDATA;
                    end else if (up_req_i && !postable && biu_req_ack_i) begin
                        burst_cnt <= biu_type2cnt(up_type_i);
                        state     <= WB_PASS;
                    end
                WB_WDATA:
                    if (biu_ack_i || biu_err_i) state <= WB_IDLE;
                WB_PASS:
                    if (biu_err_i) state <= WB_IDLE;
                    else if (biu_ack_i) begin
                        if (burst_cnt == 4'd0) state <= WB_IDLE;
                        else burst_cnt <= burst_cnt - 4'd1;
                    end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // Sticky error: a new posted-write error beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 wbuf_err_o <= 1'b0;
        else if (pop && biu_err_i) wbuf_err_o <= 1'b1;
        else if (wbuf_err_clr_i)   wbuf_err_o <= 1'b0;
    end

    assign wbuf_empty_o = rst_i | (fifo_empty & (state == WB_IDLE));

    always_comb begin
        up_req_ack_o = 1'b0;
        up_ack_o     = 1'b0;
        up_err_o     = 1'b0;
        up_q_o       = '0;
        biu_req_o    = 1'b0;
        biu_adri_o   = '0;
        biu_size_o   = BYTE;
        biu_type_o   = SINGLE;
        biu_lock_o   = 1'b0;
        biu_prot_o   = '0;
        biu_we_o     = 1'b0;
        biu_d_o      = '0;
        if (!rst_i) begin
            case (state)
                WB_IDLE:
                    if (!fifo_empty) begin
                        biu_req_o  = 1'b1;
                        biu_adri_o = head.adr;
                        biu_size_o = head.size;
                        biu_prot_o = head.prot;
                        biu_we_o   = 1'b1;
                        biu_d_o    = head.d;
                    end else if (up_req_i && !postable) begin
                        biu_req_o    = 1'b1;
                        biu_adri_o   = up_adri_i;
                        biu_size_o   = up_size_i;
                        biu_type_o   = up_type_i;
                        biu_lock_o   = up_lock_i;
                        biu_prot_o   = up_prot_i;
                        biu_we_o     = up_we_i;
                        biu_d_o      = up_d_i;
                        up_req_ack_o = biu_req_ack_i;
                    end
                WB_WDATA: biu_d_o = head.d;
                WB_PASS: begin
                    up_q_o   = biu_q_i;
                    up_ack_o = biu_ack_i;
                    up_err_o = biu_err_i;
                    biu_d_o  = up_d_i;
                end
                default: ;
            endcase
            if (push) begin
                up_req_ack_o = 1'b1;
                up_ack_o     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biu_wbuf.sv
// Directed bench for biu_wbuf: queue-level reference model checked every cycle, plus literal spot checks.
module tb_biu_wbuf;
    import biu_constants_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_i = 0, rst_i = 1;
    logic        up_req_i = 0, up_lock_i = 0, up_we_i = 0, wbuf_err_clr_i = 0;
    logic [31:0] up_adri_i = 0, up_d_i = 0, biu_adro_i = 0, biu_q_i = 0;
    biu_size_t   up_size_i = WORD;
    biu_type_t   up_type_i = SINGLE;
    biu_prot_t   up_prot_i = PROT_DATA;
    logic        biu_req_ack_i = 0, biu_d_ack_i = 0, biu_ack_i = 0, biu_err_i = 0;
    logic        up_req_ack_o, up_ack_o, up_err_o, wbuf_err_o, wbuf_empty_o;
    logic        biu_req_o, biu_lock_o, biu_we_o;
    logic [31:0] up_q_o, biu_adri_o, biu_d_o;
    biu_size_t   biu_size_o;
    biu_type_t   biu_type_o;
    biu_prot_t   biu_prot_o;

    int n_chk = 0, n_err = 0;

    biu_wbuf #(.ADDR_SIZE(32), .DATA_SIZE(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .up_req_i(up_req_i), .up_req_ack_o(up_req_ack_o), .up_adri_i(up_adri_i),
        .up_size_i(up_size_i), .up_type_i(up_type_i), .up_lock_i(up_lock_i),
        .up_prot_i(up_prot_i), .up_we_i(up_we_i), .up_d_i(up_d_i), .up_q_o(up_q_o),
        .up_ack_o(up_ack_o), .up_err_o(up_err_o), .wbuf_err_o(wbuf_err_o),
        .wbuf_err_clr_i(wbuf_err_clr_i), .wbuf_empty_o(wbuf_empty_o),
        .biu_req_o(biu_req_o), .biu_req_ack_i(biu_req_ack_i), .biu_d_ack_i(biu_d_ack_i),
        .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_lock_o(biu_lock_o), .biu_prot_o(biu_prot_o),
        .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i),
        .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of posted writes + access mode ----------------
    typedef struct {
        logic [31:0] adr;
        biu_size_t   size;
        biu_prot_t   prot;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   mmode  = 0;  // 0 nothing in flight, 1 posted write data phase, 2 pass-through
    int   mbeats = 0;
    bit   merr   = 0;

    function automatic int beats_of(input biu_type_t t);
        case (t)
            WRAP4, INCR4:   return 4;
            WRAP8, INCR8:   return 8;
            WRAP16, INCR16: return 16;
            default:        return 1;
        endcase
    endfunction

    always @(negedge clk_i) begin : cmp
        logic e_rack, e_ack, e_err, e_breq, e_bwe, e_empty, chk_d, postable, pop, acc;
        logic [31:0] e_q, e_adr, e_d;
        e_rack = 0; e_ack = 0; e_err = 0; e_breq = 0; e_bwe = 0; e_empty = 1; chk_d = 0;
        e_q = 0; e_adr = 0; e_d = 0;
        postable = up_we_i && (up_type_i == SINGLE) && !up_lock_i;
        pop = 0; acc = 0;
        if (!rst_i) begin
            pop = (mmode == 1) && (biu_ack_i || biu_err_i);
            acc = up_req_i && postable && (mq.size() < DEPTH || pop);
            e_empty = (mq.size() == 0) && (mmode == 0);
            if (mmode == 0 && mq.size() > 0) begin
                e_breq = 1; e_adr = mq[0].adr; e_bwe = 1; e_d = mq[0].d; chk_d = 1;
            end else if (mmode == 0 && up_req_i && !postable) begin
                e_breq = 1; e_adr = up_adri_i; e_bwe = up_we_i; e_rack = biu_req_ack_i;
            end
            if (mmode == 1) begin e_d = mq[0].d; chk_d = 1; end
            if (mmode == 2) begin
                e_q = biu_q_i; e_ack = biu_ack_i; e_err = biu_err_i; e_d = up_d_i; chk_d = 1;
            end
            if (acc) begin e_rack = 1; e_ack = 1; end
        end
        check("m_up_req_ack", up_req_ack_o, e_rack);
        check("m_up_ack", up_ack_o, e_ack);
        check("m_up_err", up_err_o, e_err);
        check("m_up_q", up_q_o, e_q);
        check("m_biu_req", biu_req_o, e_breq);
        check("m_wbuf_empty", wbuf_empty_o, e_empty);
        check("m_wbuf_err", wbuf_err_o, merr);
        if (e_breq) begin
            check("m_biu_adr", biu_adri_o, e_adr);
            check("m_biu_we", biu_we_o, e_bwe);
        end
        if (chk_d) check("m_biu_d", biu_d_o, e_d);

        if (rst_i) begin
            mq.delete(); mmode = 0; merr = 0; mbeats = 0;
        end else begin
            case (mmode)
                0: if (mq.size() > 0) begin
                       if (biu_req_ack_i) mmode = 1;
                   end else if (up_req_i && !postable && biu_req_ack_i) begin
                       mmode = 2; mbeats = beats_of(up_type_i);
                   end
                1: if (pop) begin void'(mq.pop_front()); mmode = 0; end
                default: if (biu_err_i) mmode = 0;
                         else if (biu_ack_i) begin
                             mbeats--;
                             if (mbeats == 0) mmode = 0;
                         end
            endcase
            if (pop && biu_err_i) merr = 1;
            else if (wbuf_err_clr_i) merr = 0;
            if (acc) mq.push_back('{up_adri_i, up_size_i, up_prot_i, up_d_i});
        end
    end

    // downstream address-phase order (1 = write)
    bit seq[$];
    always @(posedge clk_i)
        if (!rst_i && biu_req_o && biu_req_ack_i) seq.push_back(biu_we_o);

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        up_req_i = 1; up_we_i = 1; up_type_i = SINGLE; up_lock_i = 0; up_adri_i = a; up_d_i = d;
    endtask

    task automatic idle_up();
        up_req_i = 0; up_we_i = 0; up_type_i = SINGLE;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && !wbuf_empty_o; k++) begin
            biu_req_ack_i = 1; biu_ack_i = 0; tick();
            biu_req_ack_i = 0; biu_ack_i = 1; tick();
        end
        biu_ack_i = 0;
        @(negedge clk_i);
        check("drain_empty", wbuf_empty_o, 1);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        tick(); tick();
        @(negedge clk_i);
        check("rst_empty", wbuf_empty_o, 1);
        check("rst_biu_req", biu_req_o, 0);
        check("rst_err", wbuf_err_o, 0);
        rst_i = 0; tick();

        // 1: single posted write, downstream stalled
        wr(32'h1000, 32'hA5A5_0001);
        @(negedge clk_i);
        check("t1_req_ack", up_req_ack_o, 1);
        check("t1_ack", up_ack_o, 1);
        tick(); idle_up();
        @(negedge clk_i);
        check("t1_biu_req", biu_req_o, 1);
        check("t1_biu_adr", biu_adri_o, 32'h1000);
        check("t1_not_empty", wbuf_empty_o, 0);
        tick(); biu_req_ack_i = 1; tick();
        biu_req_ack_i = 0; biu_ack_i = 1;
        @(negedge clk_i);
        check("t1_biu_d", biu_d_o, 32'hA5A5_0001);
        check("t1_busy", wbuf_empty_o, 0);
        tick(); biu_ack_i = 0;
        @(negedge clk_i);
        check("t1_empty", wbuf_empty_o, 1);
        tick();

        // 2: fill the queue, fifth write waits for the first pop
        for (int i = 0; i < 4; i++) begin
            wr(32'h100 + 32'(i * 4), 32'h20 + 32'(i));
            @(negedge clk_i);
            check("t2_acc", up_req_ack_o, 1);
            tick();
        end
        wr(32'h200, 32'h25);
        @(negedge clk_i);
        check("t2_full_hold", up_req_ack_o, 0);
        tick(); biu_req_ack_i = 1;
        @(negedge clk_i);
        check("t2_full_hold2", up_req_ack_o, 0);
        tick(); biu_req_ack_i = 0;
        @(negedge clk_i);
        check("t2_wdata_hold", up_req_ack_o, 0);
        tick(); biu_ack_i = 1;
        @(negedge clk_i);
        check("t2_pop_accept", up_req_ack_o, 1);
        tick(); idle_up(); biu_ack_i = 0;
        drain();

        // 3: read waits behind two posted writes
        seq.delete();
        wr(32'h10, 32'h1); tick();
        wr(32'h14, 32'h2); tick();
        up_req_i = 1; up_we_i = 0; up_adri_i = 32'h2000;
        @(negedge clk_i);
        check("t3_rd_wait0", up_req_ack_o, 0);
        tick(); biu_req_ack_i = 1; tick();
        biu_req_ack_i = 0; biu_ack_i = 1;
        @(negedge clk_i);
        check("t3_rd_wait1", up_req_ack_o, 0);
        tick(); biu_ack_i = 0; biu_req_ack_i = 1;
        @(negedge clk_i);
        check("t3_rd_wait2", up_req_ack_o, 0);
        check("t3_w2_adr", biu_adri_o, 32'h14);
        tick(); biu_req_ack_i = 0; biu_ack_i = 1; tick();
        biu_ack_i = 0; biu_req_ack_i = 1;
        @(negedge clk_i);
        check("t3_rd_acc", up_req_ack_o, 1);
        check("t3_rd_adr", biu_adri_o, 32'h2000);
        check("t3_rd_we", biu_we_o, 0);
        tick(); idle_up(); biu_req_ack_i = 0; biu_ack_i = 1; biu_q_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("t3_rd_q", up_q_o, 32'hDEAD_BEEF);
        check("t3_rd_ack", up_ack_o, 1);
        tick(); biu_ack_i = 0; biu_q_i = 0;
        check("t3_seq_len", 64'(seq.size()), 3);
        if (seq.size() == 3) check("t3_seq", {seq[0], seq[1], seq[2]}, 3'b110);
        @(negedge clk_i);
        check("t3_empty", wbuf_empty_o, 1);
        tick();

        // 4: INCR4 read burst, a write queued during it issues right after
        up_req_i = 1; up_we_i = 0; up_type_i = INCR4; up_adri_i = 32'h3000; biu_req_ack_i = 1;
        @(negedge clk_i);
        check("t4_acc", up_req_ack_o, 1);
        tick(); biu_req_ack_i = 0;
        wr(32'h4000, 32'h44);
        tick(); idle_up();
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            biu_ack_i = 1; biu_q_i = 32'h300 + 32'(b);
            @(negedge clk_i);
            if (up_ack_o) pulses++;
            check("t4_no_req", biu_req_o, 0);
            tick();
        end
        biu_ack_i = 0;
        check("t4_pulses", 64'(pulses), 4);
        @(negedge clk_i);
        check("t4_wr_issue", biu_req_o, 1);
        check("t4_wr_adr", biu_adri_o, 32'h4000);
        tick();
        drain();

        // 5: posted write error, clear, and set-beats-clear
        wr(32'h5000, 32'h55); tick(); idle_up();
        biu_req_ack_i = 1; tick(); biu_req_ack_i = 0; biu_err_i = 1;
        @(negedge clk_i);
        check("t5_up_err", up_err_o, 0);
        tick(); biu_err_i = 0;
        @(negedge clk_i);
        check("t5_err_set", wbuf_err_o, 1);
        tick(); wbuf_err_clr_i = 1; tick(); wbuf_err_clr_i = 0;
        @(negedge clk_i);
        check("t5_err_clr", wbuf_err_o, 0);
        tick();
        wr(32'h5004, 32'h56); tick(); idle_up();
        wbuf_err_clr_i = 0; biu_req_ack_i = 1; tick(); biu_req_ack_i = 0;
        biu_err_i = 1; wbuf_err_clr_i = 1; tick(); biu_err_i = 0; wbuf_err_clr_i = 0;
        @(negedge clk_i);
        check("t5_set_wins", wbuf_err_o, 1);
        tick(); wbuf_err_clr_i = 1; tick(); wbuf_err_clr_i = 0;
        @(negedge clk_i);
        check("t5_err_clr2", wbuf_err_o, 0);
        tick();

        // 6: reset while three entries are queued and one is in its data phase
        wr(32'h600, 1); tick();
        wr(32'h604, 2); tick();
        wr(32'h608, 3); tick(); idle_up();
        biu_req_ack_i = 1; tick(); biu_req_ack_i = 0;
        rst_i = 1; tick(); rst_i = 0;
        @(negedge clk_i);
        check("t6_empty", wbuf_empty_o, 1);
        check("t6_no_req", biu_req_o, 0);
        biu_req_ack_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk_i);
            check("t6_quiet", biu_req_o, 0);
        end
        biu_req_ack_i = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
